// File: rtl/pattern_gen.sv
// pattern_gen -- video test-pattern generator for the pixel-clock domain.
//
// Takes the VTC counters and syncs and produces a registered 24-bit RGB
// stream. The syncs and active flag come out delay-matched to the pixels.
// Pattern, frame counter and box animation change only at frame start
// (FS), which is any cycle with counterX==0 and counterY==0. FS does not
// depend on sync polarity.
//
// Optional feature macro: PATTERN_GEN_BOX_EN
//   defined   -> mode 4 draws a box that bounces one BOX_STEP per frame
//   undefined -> no box registers exist; mode 4 draws the checker
//
// Ports
//   i_clk       pixel clock, the only clock
//   i_rst       synchronous active-high reset
//   i_mode      pattern select, latched at FS only
//                 0 checker, 1 colour bars, 2 ramp, 3 solid white,
//                 4 moving box, 5-7 checker
//   i_vsync     vertical sync from the VTC
//   i_hsync     horizontal sync from the VTC
//   i_active    active-video flag from the VTC
//   i_counterX  pixel X from the VTC
//   i_counterY  line Y from the VTC
//   o_rgb       {b[23:16], g[15:8], r[7:0]}; zero during blanking
//   o_vsync     i_vsync delayed 2 cycles
//   o_hsync     i_hsync delayed 2 cycles
//   o_active    i_active delayed 2 cycles
//   o_frame     frame counter, +1 at every FS, wraps 255 -> 0
//
// Flow control: there is no valid/ready handshake. One pixel is accepted on
// every clock, and each output pixel is valid exactly two cycles after its
// input. o_active tells the pixel apart from blanking.
//
// Pipeline
//   stage 1 registers X, Y, active, syncs and the decode inputs: mode,
//           frame and box position.
//   stage 2 registers o_rgb together with the delayed syncs and active.

module pattern_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int CW         = 10,
   parameter int CHECK_LOG2 = 4,
   parameter int BOX_SIZE   = 32,
   parameter int BOX_STEP   = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [2:0]    i_mode,
   input  logic          i_vsync,
   input  logic          i_hsync,
   input  logic          i_active,
   input  logic [CW-1:0] i_counterX,
   input  logic [CW-1:0] i_counterY,
   output logic [23:0]   o_rgb,
   output logic          o_vsync,
   output logic          o_hsync,
   output logic          o_active,
   output logic [7:0]    o_frame
);

   localparam int BAR_W = H_ACTIVE / 8;

   // ------------------------------------------------------------------
   // Frame-start state: mode latch, frame counter and box position
   // ------------------------------------------------------------------
   logic       fs;
   logic [2:0] mode_q, mode_nxt;
   logic [7:0] frame_q, frame_nxt;

   assign fs = (i_counterX == '0) && (i_counterY == '0);

   // Stage 1 captures these next-state values. The FS pixel itself is
   // therefore already drawn with the new mode, frame and box position.
   always_comb begin
      mode_nxt  = mode_q;
      frame_nxt = frame_q;
      if (fs) begin
         mode_nxt  = i_mode;
         frame_nxt = frame_q + 8'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mode_q  <= 3'd0;
         frame_q <= 8'd0;
      end else begin
         mode_q  <= mode_nxt;
         frame_q <= frame_nxt;
      end
   end

   assign o_frame = frame_q;

`ifdef PATTERN_GEN_BOX_EN
   localparam int X_LIM = H_ACTIVE - BOX_SIZE;
   localparam int Y_LIM = V_ACTIVE - BOX_SIZE;

   // One axis of box motion. The result is {direction_negative, position}.
   // Overshooting either edge clamps to that edge and flips the direction
   // in the same step.
   function automatic logic [CW:0] step_axis(input logic [CW-1:0] p,
                                             input logic          neg,
                                             input int            lim);
      int          t;
      logic [CW:0] r;
      t = neg ? (int'(p) - BOX_STEP) : (int'(p) + BOX_STEP);
      if (t > lim)
         r = {1'b1, CW'(lim)};
      else if (t < 0)
         r = {1'b0, {CW{1'b0}}};
      else
         r = {neg, t[CW-1:0]};
      return r;
   endfunction

   logic [CW-1:0] bx_q, by_q, bx_nxt, by_nxt;
   logic          dx_neg_q, dy_neg_q, dx_neg_nxt, dy_neg_nxt;

   always_comb begin
      {dx_neg_nxt, bx_nxt} = {dx_neg_q, bx_q};
      {dy_neg_nxt, by_nxt} = {dy_neg_q, by_q};
      if (fs) begin
         {dx_neg_nxt, bx_nxt} = step_axis(bx_q, dx_neg_q, X_LIM);
         {dy_neg_nxt, by_nxt} = step_axis(by_q, dy_neg_q, Y_LIM);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bx_q     <= '0;
         by_q     <= '0;
         dx_neg_q <= 1'b0;
         dy_neg_q <= 1'b0;
      end else begin
         bx_q     <= bx_nxt;
         by_q     <= by_nxt;
         dx_neg_q <= dx_neg_nxt;
         dy_neg_q <= dy_neg_nxt;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Stage 1
   // ------------------------------------------------------------------
   logic [CW-1:0] s1_x, s1_y;
   logic          s1_active, s1_hsync, s1_vsync;
   logic [2:0]    s1_mode;
   logic [7:0]    s1_frame;
`ifdef PATTERN_GEN_BOX_EN
   logic [CW-1:0] s1_bx, s1_by;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_x      <= '0;
         s1_y      <= '0;
         s1_active <= 1'b0;
         s1_hsync  <= 1'b0;
         s1_vsync  <= 1'b0;
         s1_mode   <= 3'd0;
         s1_frame  <= 8'd0;
`ifdef PATTERN_GEN_BOX_EN
         s1_bx     <= '0;
         s1_by     <= '0;
`endif
      end else begin
         s1_x      <= i_counterX;
         s1_y      <= i_counterY;
         s1_active <= i_active;
         s1_hsync  <= i_hsync;
         s1_vsync  <= i_vsync;
         s1_mode   <= mode_nxt;
         s1_frame  <= frame_nxt;
`ifdef PATTERN_GEN_BOX_EN
         s1_bx     <= bx_nxt;
         s1_by     <= by_nxt;
`endif
      end
   end

`ifndef PATTERN_GEN_BOX_EN
   // Without the box, only some Y bits feed a pattern.
   logic unused_y;
   assign unused_y = ^s1_y;
`endif

   // ------------------------------------------------------------------
   // Pattern decode (combinational, from the stage-1 registers)
   // ------------------------------------------------------------------
   logic [23:0] checker_rgb, bars_rgb, ramp_rgb, pat_rgb;
   logic [2:0]  bar, bar_code;
`ifdef PATTERN_GEN_BOX_EN
   logic        in_box;
   logic [23:0] box_rgb;
`endif

   assign checker_rgb = (s1_x[CHECK_LOG2] ^ s1_y[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000;

   // The bar index is the highest k with X >= k*BAR_W. X values past the
   // last whole bar therefore stay in bar 7, which is black.
   always_comb begin
      bar = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (int'(s1_x) >= k * BAR_W) bar = 3'(k);
      end
   end

   // bar_code = 7 - bar. Bit 2 drives red, bit 1 green and bit 0 blue, so
   // the bars run white, yellow, magenta, red, cyan, green, blue, black.
   assign bar_code = ~bar;
   assign bars_rgb = {{8{bar_code[0]}}, {8{bar_code[1]}}, {8{bar_code[2]}}};

   assign ramp_rgb = {s1_frame, s1_y[7:0], s1_x[7:0]};

`ifdef PATTERN_GEN_BOX_EN
   assign in_box  = (int'(s1_x) >= int'(s1_bx)) && (int'(s1_x) < int'(s1_bx) + BOX_SIZE) &&
                    (int'(s1_y) >= int'(s1_by)) && (int'(s1_y) < int'(s1_by) + BOX_SIZE);
   assign box_rgb = in_box ? 24'hFFFFFF : 24'h800000;
`endif

   always_comb begin
      pat_rgb = checker_rgb;
      case (s1_mode)
         3'd1:    pat_rgb = bars_rgb;
         3'd2:    pat_rgb = ramp_rgb;
         3'd3:    pat_rgb = 24'hFFFFFF;
`ifdef PATTERN_GEN_BOX_EN
         3'd4:    pat_rgb = box_rgb;
`endif
         default: pat_rgb = checker_rgb;
      endcase
   end

   // ------------------------------------------------------------------
   // Stage 2
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rgb    <= 24'h0;
         o_vsync  <= 1'b0;
         o_hsync  <= 1'b0;
         o_active <= 1'b0;
      end else begin
         o_rgb    <= s1_active ? pat_rgb : 24'h0;
         o_vsync  <= s1_vsync;
         o_hsync  <= s1_hsync;
         o_active <= s1_active;
      end
   end

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen -- directed bench for pattern_gen with default parameters.
// The driver sets one pixel per clock. Every checked pixel pushes
// {due_cycle, x, y, rgb, vsync/hsync/active} onto exp_q. The monitor
// compares every entry whose due cycle has come.

module tb_pattern_gen;

   localparam int W = 79; // 32 due + 10 x + 10 y + 24 rgb + 3 flags

`ifdef PATTERN_GEN_BOX_EN
   localparam bit BOX = 1'b1;
`else
   localparam bit BOX = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  mode;
   logic        vsync, hsync, active;
   logic [9:0]  cx, cy;
   logic [23:0] rgb;
   logic        ovs, ohs, oact;
   logic [7:0]  frame;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   pattern_gen dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_mode     (mode),
      .i_vsync    (vsync),
      .i_hsync    (hsync),
      .i_active   (active),
      .i_counterX (cx),
      .i_counterY (cy),
      .o_rgb      (rgb),
      .o_vsync    (ovs),
      .o_hsync    (ohs),
      .o_active   (oact),
      .o_frame    (frame)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      logic [W-1:0] e;
      while (exp_q.size() > 0 && exp_q[0][78:47] == 32'(cyc)) begin
         e = exp_q.pop_front();
         check($sformatf("rgb(%0d,%0d)", e[46:37], e[36:27]), {8'h0, rgb}, {8'h0, e[26:3]});
         check($sformatf("sync_act(%0d,%0d)", e[46:37], e[36:27]),
               {29'h0, ovs, ohs, oact}, {29'h0, e[2:0]});
      end
   end

   // ---------------- driver tasks ----------------
   // One checked pixel. r drives reset on its sample edge. z marks a pixel
   // that a reset wipes out, either on its own edge or on the next one.
   task automatic pix(input int x, input int y, input logic a, input logic r,
                      input logic [23:0] e, input logic z);
      logic [9:0] xv, yv;
      logic [2:0] ef;
      @(negedge clk);
      xv = 10'(x);
      yv = 10'(y);
      rst = r; cx = xv; cy = yv; active = a; hsync = xv[1]; vsync = yv[1];
      ef = z ? 3'b000 : {yv[1], xv[1], a};
      exp_q.push_back({32'(cyc + 2), xv, yv, (z ? 24'h0 : e), ef});
   endtask

   // n consecutive unchecked frame-start cycles
   task automatic fs_run(input int n);
      repeat (n) begin
         @(negedge clk);
         rst = 1'b0; cx = 10'd0; cy = 10'd0; active = 1'b1; hsync = 1'b0; vsync = 1'b0;
      end
   endtask

   // o_frame just after the edge that samples the last driven input
   task automatic frame_chk(input string name, input logic [7:0] want);
      @(posedge clk);
      #1;
      check(name, {24'h0, frame}, {24'h0, want});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; mode = 3'd0; cx = '0; cy = '0; active = 1'b0; hsync = 1'b0; vsync = 1'b0;

      // power-on reset, then the first pixel after release
      repeat (3) pix(5, 5, 1, 1, 24'h0, 1);
      frame_chk("reset_frame", 8'd0);
      pix(16, 5, 1, 0, 24'hFFFFFF, 0);
      pix(0, 0, 1, 0, 24'h000000, 0);        // FS -> frame 1, checker
      frame_chk("fs1_frame", 8'd1);

      // checker
      pix(15, 0, 1, 0, 24'h000000, 0);
      pix(16, 0, 1, 0, 24'hFFFFFF, 0);
      pix(16, 16, 1, 0, 24'h000000, 0);
      pix(0, 16, 1, 0, 24'hFFFFFF, 0);
      pix(48, 35, 1, 0, 24'hFFFFFF, 0);
      pix(16, 0, 0, 0, 24'h000000, 0);       // blanked

      // mode latching: a mid-frame change is ignored until FS
      mode = 3'd2;
      pix(16, 0, 1, 0, 24'hFFFFFF, 0);
      pix(31, 31, 1, 0, 24'h000000, 0);
      pix(0, 0, 1, 0, 24'h020000, 0);        // FS -> ramp, frame 2
      frame_chk("ramp_frame", 8'd2);
      pix(53, 18, 1, 0, 24'h021235, 0);
      pix(300, 257, 1, 0, 24'h02012C, 0);

      // colour bars
      mode = 3'd1;
      pix(0, 0, 1, 0, 24'hFFFFFF, 0);        // FS -> frame 3, bar 0
      pix(79, 5, 1, 0, 24'hFFFFFF, 0);
      pix(80, 5, 1, 0, 24'h00FFFF, 0);
      pix(160, 5, 1, 0, 24'hFF00FF, 0);
      pix(559, 5, 1, 0, 24'hFF0000, 0);
      pix(560, 5, 1, 0, 24'h000000, 0);
      pix(639, 5, 1, 0, 24'h000000, 0);

      // solid white
      mode = 3'd3;
      pix(0, 0, 1, 0, 24'hFFFFFF, 0);        // FS -> frame 4
      frame_chk("solid_frame", 8'd4);
      pix(123, 77, 1, 0, 24'hFFFFFF, 0);
      pix(123, 77, 0, 0, 24'h000000, 0);

      // reset mid-line: zero on the next edge, resume in checker mode
      mode = 3'd1;
      pix(200, 9, 1, 0, 24'h0, 1);
      pix(201, 9, 1, 1, 24'h0, 1);
      pix(202, 9, 1, 1, 24'h0, 1);
      pix(203, 9, 1, 1, 24'h0, 1);
      frame_chk("midrst_frame", 8'd0);
      pix(16, 9, 1, 0, 24'hFFFFFF, 0);
      pix(5, 9, 1, 0, 24'h000000, 0);
      frame_chk("post_rst_frame", 8'd0);

      // mode 4: box at (2,2) after one FS, or checker without the box
      mode = 3'd4;
      pix(0, 0, 1, 0, BOX ? 24'h800000 : 24'h000000, 0);
      frame_chk("box_frame", 8'd1);
      pix(2, 2, 1, 0, BOX ? 24'hFFFFFF : 24'h000000, 0);
      pix(1, 2, 1, 0, BOX ? 24'h800000 : 24'h000000, 0);
      pix(16, 2, 1, 0, 24'hFFFFFF, 0);
      pix(33, 33, 1, 0, BOX ? 24'hFFFFFF : 24'h000000, 0);
      pix(40, 2, 1, 0, BOX ? 24'h800000 : 24'h000000, 0);

      // frame counter wrap, then reset on an FS cycle
      fs_run(254);
      frame_chk("frame_255", 8'd255);
      fs_run(1);
      frame_chk("frame_wrap", 8'd0);
      fs_run(1);
      frame_chk("frame_after_wrap", 8'd1);
      pix(0, 0, 1, 1, 24'h0, 1);             // reset beats FS
      frame_chk("rst_on_fs_frame", 8'd0);
      pix(7, 7, 1, 0, 24'h000000, 0);        // checker, the reset left mode 0
      frame_chk("rst_on_fs_hold", 8'd0);

`ifdef PATTERN_GEN_BOX_EN
      // box bounce: the reset above cleared the box to (0,0) moving +,+
      mode = 3'd4;
      fs_run(304);                           // bx=608, by=290 (Y bounced at 448)
      pix(608, 290, 1, 0, 24'hFFFFFF, 0);
      pix(607, 290, 1, 0, 24'h800000, 0);
      pix(639, 321, 1, 0, 24'hFFFFFF, 0);
      pix(608, 322, 1, 0, 24'h800000, 0);
      fs_run(1);                             // 610 overshoots: clamp 608, by=288
      pix(608, 288, 1, 0, 24'hFFFFFF, 0);
      pix(607, 288, 1, 0, 24'h800000, 0);
      fs_run(1);                             // moving left: bx=606, by=286
      pix(606, 286, 1, 0, 24'hFFFFFF, 0);
      pix(637, 286, 1, 0, 24'hFFFFFF, 0);
      pix(638, 286, 1, 0, 24'h800000, 0);
`endif

      // drain the pipeline and confirm every expectation was consumed
      repeat (4) @(negedge clk);
      check("queue_drain", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
